fifo_sync_rd_stream: RTL and testbench

- Read-side drain engine for fifo_sync. It converts the FIFO read port (empty flag, read strobe, registered read data) into a valid/ready stream for downstream consumers.
- Buffering: a 2-entry output skid buffer, so the block sustains one word per clock despite the FIFO's 1-cycle read latency.
- Extra features: a synchronous flush and a delivered-word counter for debug and performance monitoring.

---
 rtl/fifo_sync_rd_stream.sv | 122 ++++++++++++
 tb/tb_fifo_sync_rd_stream.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_rd_stream.sv
// fifo_sync_rd_stream: drains the fifo_sync read port into a valid/ready stream
// through a 2-entry skid buffer, with synchronous flush and a delivered-word counter.
module fifo_sync_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_flush,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_busy
);

  logic [1:0]            occ_r;
  logic [1:0]            occ_next_s;
  logic                  inflight_r;
  logic                  inflight_next_s;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] head_next_s;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [DATA_WIDTH-1:0] tail_next_s;
  logic [CNT_WIDTH-1:0]  count_r;
  logic [CNT_WIDTH-1:0]  count_next_s;
  logic                  valid_r;
  logic                  valid_next_s;
  logic                  busy_r;
  logic                  busy_next_s;
  logic                  pop_s;
  logic                  rd_s;
  logic [2:0]            level_s;

  // Read issue looks at this cycle's pop so a draining buffer refills without a bubble.
  always_comb begin
    pop_s   = valid_r & i_ready;
    level_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    rd_s    = ~i_rst & ~i_fifo_empty & ~i_flush & (level_s < 3'd2);
  end

  // Skid-buffer next state: head/tail shuffle, flush discard and handshake counter.
  always_comb begin
    occ_next_s      = occ_r;
    inflight_next_s = rd_s;
    head_next_s     = head_r;
    tail_next_s     = tail_r;
    if (pop_s) begin
      count_next_s = count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_next_s = count_r;
    end
    if (i_flush) begin
      occ_next_s      = 2'd0;
      inflight_next_s = 1'b0;
    end else begin
      case ({inflight_r, pop_s})
        2'b01: begin
          occ_next_s = occ_r - 2'd1;
          // With a single entry the head is left alone so o_data holds the last word.
          if (occ_r == 2'd2) begin
            head_next_s = tail_r;
          end else begin
            head_next_s = head_r;
          end
        end
        2'b10: begin
          occ_next_s = occ_r + 2'd1;
          if (occ_r == 2'd0) begin
            head_next_s = i_fifo_data;
          end else begin
            tail_next_s = i_fifo_data;
          end
        end
        2'b11: begin
          if (occ_r == 2'd2) begin
            head_next_s = tail_r;
            tail_next_s = i_fifo_data;
          end else begin
            head_next_s = i_fifo_data;
          end
        end
        default: begin
          occ_next_s = occ_r;
        end
      endcase
    end
    valid_next_s = (occ_next_s != 2'd0);
    busy_next_s  = valid_next_s | inflight_next_s;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      head_r     <= {DATA_WIDTH{1'b0}};
      tail_r     <= {DATA_WIDTH{1'b0}};
      count_r    <= {CNT_WIDTH{1'b0}};
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      occ_r      <= occ_next_s;
      inflight_r <= inflight_next_s;
      head_r     <= head_next_s;
      tail_r     <= tail_next_s;
      count_r    <= count_next_s;
      valid_r    <= valid_next_s;
      busy_r     <= busy_next_s;
    end
  end

  assign o_fifo_rd = rd_s;
  assign o_valid   = valid_r;
  assign o_data    = head_r;
  assign o_count   = count_r;
  assign o_busy    = busy_r;

endmodule

// File: tb/tb_fifo_sync_rd_stream.sv
// Bench for fifo_sync_rd_stream: behavioural fifo_sync model plus a scoreboard of
// words pushed into the model, compared in order against stream handshakes.
module tb_fifo_sync_rd_stream;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_data;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          flush;
  logic [CW-1:0] count;
  logic          busy;

  logic [DW-1:0] mem [0:255];
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic [DW-1:0] exp_q [$];
  int            checks = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_cnt == rd_cnt);

  // fifo_sync model: registered read data one cycle after an accepted read.
  always @(posedge clk) begin
    if (rst) begin
      rd_cnt    <= wr_cnt;
      fifo_data <= '0;
    end else if (fifo_rd && !fifo_empty) begin
      fifo_data <= mem[rd_cnt % 256];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  fifo_sync_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_fifo_empty(fifo_empty), .o_fifo_rd(fifo_rd),
    .i_fifo_data(fifo_data), .o_valid(valid), .i_ready(ready), .o_data(data),
    .i_flush(flush), .o_count(count), .o_busy(busy)
  );

  task automatic push(input logic [DW-1:0] w);
    mem[wr_cnt % 256] = w;
    wr_cnt = wr_cnt + 1;
    exp_q.push_back(w);
  endtask

  task automatic test_reset();
    int first_v = -1;
    int n_hs = 0;
    int last_hs = -1;
    logic [DW-1:0] e;
    rst = 1'b1; ready = 1'b1; flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fifo_rd, valid, busy} !== 3'b000 || data !== '0 || count !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rd=%b valid=%b busy=%b data=%h count=%h, required all 0",
               fifo_rd, valid, busy, data, count);
    end
    push(32'h0000_00A0); push(32'h0000_00A1); push(32'h0000_00A2);
    rst = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        checks++;
        if (fifo_rd !== 1'b1) begin fails++; $display("FAIL rd_after_release: got %b, required 1", fifo_rd); end
      end
      if (valid === 1'b1 && first_v < 0) first_v = c;
      checks++;
      if (fifo_rd === 1'b1 && fifo_empty) begin fails++; $display("FAIL rd_while_empty: rd=1 with empty=1, required 0"); end
      if (valid === 1'b1 && ready === 1'b1) begin
        checks++; n_hs++; last_hs = c;
        if (exp_q.size() == 0) begin fails++; $display("FAIL reset_data: got %h, required no word", data); end
        else begin
          e = exp_q.pop_front();
          if (data !== e) begin fails++; $display("FAIL reset_data: got %h, required %h", data, e); end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (first_v != 2) begin fails++; $display("FAIL reset_latency: valid at cycle %0d, required 2", first_v); end
    checks++;
    if (n_hs != 3 || last_hs != 4) begin fails++; $display("FAIL reset_gapless: %0d words last at %0d, required 3 last at 4", n_hs, last_hs); end
    checks++;
    if (count !== 16'd3 || busy !== 1'b0 || valid !== 1'b0) begin
      fails++; $display("FAIL reset_final: count=%0d busy=%b valid=%b, required 3/0/0", count, busy, valid);
    end
  endtask

  task automatic test_backpressure();
    int reads = 0;
    int level0;
    int n_hs = 0;
    int first_hs = -1;
    int last_hs = -1;
    logic [DW-1:0] e;
    ready = 1'b0;
    push(32'h0000_00A0); push(32'h0000_00A1); push(32'h0000_00A2);
    level0 = wr_cnt - rd_cnt;
    #1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (fifo_rd === 1'b1 && fifo_empty) begin fails++; $display("FAIL bp_rd_while_empty: rd=1 with empty=1, required 0"); end
      if (fifo_rd === 1'b1 && !fifo_empty) reads++;
      @(negedge clk);
    end
    checks++;
    if (reads != 2 || fifo_rd !== 1'b0 || valid !== 1'b1) begin
      fails++; $display("FAIL bp_hold: reads=%0d rd=%b valid=%b, required 2/0/1", reads, fifo_rd, valid);
    end
    ready = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (valid === 1'b1 && ready === 1'b1) begin
        checks++; n_hs++; last_hs = c;
        if (first_hs < 0) first_hs = c;
        if (exp_q.size() == 0) begin fails++; $display("FAIL bp_data: got %h, required no word", data); end
        else begin
          e = exp_q.pop_front();
          if (data !== e) begin fails++; $display("FAIL bp_data: got %h, required %h", data, e); end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n_hs != 3 || last_hs - first_hs != 2) begin fails++; $display("FAIL bp_gapless: %0d words span %0d, required 3 span 2", n_hs, last_hs - first_hs); end
    checks++;
    if (level0 - (wr_cnt - rd_cnt) != 3) begin fails++; $display("FAIL bp_fill_drop: dropped %0d, required 3", level0 - (wr_cnt - rd_cnt)); end
    checks++;
    if (count !== 16'd6) begin fails++; $display("FAIL bp_count: got %0d, required 6", count); end
  endtask

  task automatic test_empty();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ready = 1'b1;
    exp_q.delete();
    #1;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (fifo_rd !== 1'b0 || valid !== 1'b0 || count !== '0) begin
        fails++; $display("FAIL empty_idle: rd=%b valid=%b count=%0d, required 0/0/0", fifo_rd, valid, count);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stream();
    int n_hs = 0;
    int c = 0;
    logic [DW-1:0] e;
    for (int i = 0; i < 100; i++) push($urandom);
    while (n_hs < 100 && c < 500) begin
      ready = (c % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      checks++;
      if (fifo_rd === 1'b1 && fifo_empty) begin fails++; $display("FAIL stream_rd_while_empty: rd=1 with empty=1, required 0"); end
      if (valid === 1'b1 && ready === 1'b1) begin
        checks++; n_hs++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL stream_data: got %h, required no word", data); end
        else begin
          e = exp_q.pop_front();
          if (data !== e) begin fails++; $display("FAIL stream_data: word %0d got %h, required %h", n_hs, data, e); end
        end
      end
      @(negedge clk);
      c++;
    end
    checks++;
    if (n_hs != 100) begin fails++; $display("FAIL stream_timeout: %0d words delivered, required 100", n_hs); end
    checks++;
    if (count !== 16'd100 || exp_q.size() != 0) begin
      fails++; $display("FAIL stream_count: count=%0d left=%0d, required 100/0", count, exp_q.size());
    end
  endtask

  task automatic test_flush();
    int first_v = -1;
    logic [DW-1:0] e;
    ready = 1'b0;
    push(32'h0000_00B0); push(32'h0000_00B1); push(32'h0000_00B2); push(32'h0000_00B3);
    repeat (6) @(negedge clk);
    ready = 1'b1;
    #1;
    checks++;
    e = exp_q.pop_front();
    if (valid !== 1'b1 || data !== e || fifo_rd !== 1'b1) begin
      fails++; $display("FAIL flush_setup: valid=%b data=%h rd=%b, required 1/%h/1", valid, data, fifo_rd, e);
    end
    @(negedge clk);
    ready = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if (fifo_rd !== 1'b0 || count !== 16'd101) begin
      fails++; $display("FAIL flush_cycle: rd=%b count=%0d, required 0/101", fifo_rd, count);
    end
    @(negedge clk);
    flush = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || count !== 16'd101 || fifo_rd !== 1'b1) begin
      fails++; $display("FAIL flush_after: valid=%b busy=%b count=%0d rd=%b, required 0/0/101/1", valid, busy, count, fifo_rd);
    end
    ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (valid === 1'b1 && first_v < 0) first_v = c;
      if (valid === 1'b1 && ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL flush_data: got %h, required no word", data); end
        else begin
          e = exp_q.pop_front();
          if (data !== e) begin fails++; $display("FAIL flush_data: got %h, required %h", data, e); end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (first_v != 2 || count !== 16'd102) begin
      fails++; $display("FAIL flush_resume: valid at %0d count=%0d, required 2/102", first_v, count);
    end
    ready = 1'b0;
    push(32'h0000_00C0); push(32'h0000_00C1);
    repeat (4) @(negedge clk);
    ready = 1'b1; flush = 1'b1;
    #1;
    checks++;
    e = exp_q.pop_front();
    if (valid !== 1'b1 || data !== e || fifo_rd !== 1'b0) begin
      fails++; $display("FAIL flush_pop: valid=%b data=%h rd=%b, required 1/%h/0", valid, data, fifo_rd, e);
    end
    @(negedge clk);
    flush = 1'b0; ready = 1'b0;
    void'(exp_q.pop_front());
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || count !== 16'd103) begin
      fails++; $display("FAIL flush_pop_count: valid=%b busy=%b count=%0d, required 0/0/103", valid, busy, count);
    end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int n_hs = 0;
    int c = 0;
    logic [CW-1:0] exp_cnt;
    logic [DW-1:0] e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ready = 1'b1;
    exp_q.delete();
    while (n_hs < 65534 && c < 70000) begin
      if (pushed < 65534 && (wr_cnt - rd_cnt) < 64) begin
        push(pushed);
        pushed++;
      end
      if (valid === 1'b1 && ready === 1'b1) begin
        checks++; n_hs++;
        e = exp_q.pop_front();
        if (data !== e) begin fails++; $display("FAIL wrap_data: got %h, required %h", data, e); end
      end
      @(negedge clk);
      c++;
    end
    checks++;
    if (n_hs != 65534 || count !== 16'hFFFE) begin
      fails++; $display("FAIL wrap_preset: %0d words count=%h, required 65534/FFFE", n_hs, count);
    end
    exp_cnt = 16'hFFFE;
    push(32'hD0); push(32'hD1); push(32'hD2);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (count !== exp_cnt) begin fails++; $display("FAIL wrap_count: got %h, required %h", count, exp_cnt); end
      if (valid === 1'b1 && ready === 1'b1) begin
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        e = exp_q.pop_front();
        if (data !== e) begin fails++; $display("FAIL wrap_tail_data: got %h, required %h", data, e); end
      end
      @(negedge clk);
    end
    checks++;
    if (count !== 16'h0001) begin fails++; $display("FAIL wrap_final: got %h, required 0001", count); end
    ready = 1'b0;
    push(32'hE0); push(32'hE1); push(32'hE2); push(32'hE3);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({fifo_rd, valid, busy} !== 3'b000 || data !== '0 || count !== '0) begin
      fails++; $display("FAIL async_reset: rd=%b valid=%b busy=%b data=%h count=%h, required all 0",
                        fifo_rd, valid, busy, data, count);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; flush = 1'b0;
    test_reset();
    test_backpressure();
    test_empty();
    test_stream();
    test_flush();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
